// File: rtl/matrix_ram_responder.sv
// rtl/matrix_ram_responder.sv - matrix RAM responder serving 4x4 signed matrices one row per cycle
module matrix_ram_responder #(
  parameter int Depth     = 8,
  parameter int DataWidth = 32
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        RAMEnable,
  input  logic                        ReadWrite,
  input  logic [31:0]                 AddressSelect,
  input  logic                        ClearAll,
  input  logic signed [DataWidth-1:0] WrData0,
  input  logic signed [DataWidth-1:0] WrData1,
  input  logic signed [DataWidth-1:0] WrData2,
  input  logic signed [DataWidth-1:0] WrData3,
  output logic signed [DataWidth-1:0] RdData0,
  output logic signed [DataWidth-1:0] RdData1,
  output logic signed [DataWidth-1:0] RdData2,
  output logic signed [DataWidth-1:0] RdData3,
  output logic [1:0]                  RowIndex,
  output logic                        RowValid,
  output logic                        Busy,
  output logic                        RAMDone,
  output logic                        AddrError
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                      state_q;
  logic                        armed_q;
  logic                        wr_q;
  logic                        oor_q;
  logic [AW-1:0]               addr_q;
  logic [1:0]                  row_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        err_q;
  logic signed [DataWidth-1:0] rd_q [4];

  logic signed [DataWidth-1:0] mem [Depth][4][4];
  logic signed [DataWidth-1:0] wr_row [4];

  logic                        accept;
  logic                        acc_oor;
  logic                        rd_load;
  logic                        rd_oor;
  logic [AW-1:0]               rd_idx;
  logic [1:0]                  rd_row;
  logic signed [DataWidth-1:0] rd_d [4];

  assign accept  = (state_q == IDLE) && RAMEnable && armed_q && !ClearAll;
  assign acc_oor = (AddressSelect >= 32'(Depth));
  assign wr_row  = '{WrData0, WrData1, WrData2, WrData3};

  // The read row for the next cycle is fetched one edge early so RdData is
  // already stable for the whole cycle in which RowValid announces it.
  always_comb begin
    rd_load = 1'b0;
    rd_idx  = addr_q;
    rd_row  = row_q + 2'd1;
    rd_oor  = oor_q;
    if (accept && !ReadWrite) begin
      rd_load = 1'b1;
      rd_idx  = AddressSelect[AW-1:0];
      rd_row  = 2'd0;
      rd_oor  = acc_oor;
    end else if (state_q == XFER && !wr_q && row_q != 2'd3) begin
      rd_load = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      rd_d[c] = rd_oor ? '0 : mem[rd_idx][rd_row][c];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      row_q   <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < 4; c++) rd_q[c] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (rd_load) begin
        for (int c = 0; c < 4; c++) rd_q[c] <= rd_d[c];
      end
      case (state_q)
        IDLE: begin
          if (!RAMEnable) armed_q <= 1'b1;
          if (accept) begin
            addr_q  <= AddressSelect[AW-1:0];
            oor_q   <= acc_oor;
            wr_q    <= ReadWrite;
            row_q   <= 2'd0;
            armed_q <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (row_q == 2'd3) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= oor_q;
            state_q <= DONE;
          end else begin
            row_q <= row_q + 2'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage has no reset; writes are gated by the FSM so a reset mid-write
  // leaves the rows already committed.
  always_ff @(posedge Clock) begin
    if (state_q == IDLE && ClearAll) begin
      for (int m = 0; m < Depth; m++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            mem[m][r][c] <= '0;
    end else if (state_q == XFER && wr_q && !oor_q) begin
      for (int c = 0; c < 4; c++) mem[addr_q][row_q][c] <= wr_row[c];
    end
  end

  assign RdData0   = rd_q[0];
  assign RdData1   = rd_q[1];
  assign RdData2   = rd_q[2];
  assign RdData3   = rd_q[3];
  assign RowIndex  = row_q;
  assign RowValid  = valid_q;
  assign Busy      = busy_q;
  assign RAMDone   = done_q;
  assign AddrError = err_q;

endmodule

// File: tb/tb_matrix_ram_responder.sv
// tb/tb_matrix_ram_responder.sv - randomized self-checking bench for matrix_ram_responder
module tb_matrix_ram_responder;

  logic               Clock = 1'b0;
  logic               Reset = 1'b0;
  logic               RAMEnable = 1'b0;
  logic               ReadWrite = 1'b0;
  logic [31:0]        AddressSelect = '0;
  logic               ClearAll = 1'b0;
  logic signed [31:0] WrData0 = '0, WrData1 = '0, WrData2 = '0, WrData3 = '0;
  logic signed [31:0] RdData0, RdData1, RdData2, RdData3;
  logic [1:0]         RowIndex;
  logic               RowValid, Busy, RAMDone, AddrError;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [31:0] model [8][4][4];
  logic signed [31:0] wdata [4][4];
  logic signed [31:0] got_rows [4][4];
  logic signed [31:0] rd [4];

  assign rd[0] = RdData0;
  assign rd[1] = RdData1;
  assign rd[2] = RdData2;
  assign rd[3] = RdData3;

  matrix_ram_responder #(.Depth(8), .DataWidth(32)) dut (
    .Clock(Clock), .Reset(Reset), .RAMEnable(RAMEnable), .ReadWrite(ReadWrite),
    .AddressSelect(AddressSelect), .ClearAll(ClearAll),
    .WrData0(WrData0), .WrData1(WrData1), .WrData2(WrData2), .WrData3(WrData3),
    .RdData0(RdData0), .RdData1(RdData1), .RdData2(RdData2), .RdData3(RdData3),
    .RowIndex(RowIndex), .RowValid(RowValid), .Busy(Busy), .RAMDone(RAMDone),
    .AddrError(AddrError)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] exp_el(input logic [31:0] addr, input int r, input int c);
    if (addr >= 32'd8) return '0;
    return model[addr[2:0]][r][c];
  endfunction

  task automatic fill_const(input logic signed [31:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wdata[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wdata[r][c] = $urandom;
  endtask

  // One full access driven from a falling edge in IDLE; abort_row >= 0 pulls
  // Reset low during that row, hold keeps RAMEnable high afterwards, and
  // clr_mid pulses ClearAll during row 1.
  task automatic access(input bit wr, input logic [31:0] addr, input int abort_row,
                        input bit hold, input bit clr_mid);
    RAMEnable = 1'b0;
    @(negedge Clock);
    RAMEnable     = 1'b1;
    ReadWrite     = wr;
    AddressSelect = addr;
    for (int r = 0; r < 4; r++) begin
      @(negedge Clock);
      if (r == 0) begin
        if (!hold) RAMEnable = 1'b0;
        AddressSelect = $urandom;
        ReadWrite     = $urandom_range(0, 1);
      end
      if (r == abort_row) begin
        Reset = 1'b0;
        #1;
        check("abort_rowvalid", {31'b0, RowValid}, 32'd0);
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_done", {31'b0, RAMDone}, 32'd0);
        for (int c = 0; c < 4; c++) check("abort_rddata", rd[c], 32'd0);
        if (wr && addr < 32'd8)
          for (int rr = 0; rr < r; rr++)
            for (int c = 0; c < 4; c++) model[addr[2:0]][rr][c] = wdata[rr][c];
        @(negedge Clock);
        Reset = 1'b1;
        RAMEnable = 1'b0;
        return;
      end
      ClearAll = clr_mid && (r == 1);
      check("xfer_rowvalid", {31'b0, RowValid}, 32'd1);
      check("xfer_rowindex", {30'b0, RowIndex}, r);
      check("xfer_busy", {31'b0, Busy}, 32'd1);
      check("xfer_done", {31'b0, RAMDone}, 32'd0);
      if (!wr)
        for (int c = 0; c < 4; c++) begin
          check("read_data", rd[c], exp_el(addr, r, c));
          got_rows[r][c] = rd[c];
        end
      WrData0 = wdata[r][0];
      WrData1 = wdata[r][1];
      WrData2 = wdata[r][2];
      WrData3 = wdata[r][3];
    end
    @(negedge Clock);
    ClearAll = 1'b0;
    check("done_pulse", {31'b0, RAMDone}, 32'd1);
    check("done_addrerr", {31'b0, AddrError}, {31'b0, addr >= 32'd8});
    check("done_rowvalid", {31'b0, RowValid}, 32'd0);
    check("done_busy", {31'b0, Busy}, 32'd1);
    if (wr && addr < 32'd8)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) model[addr[2:0]][r][c] = wdata[r][c];
    @(negedge Clock);
    check("idle_done", {31'b0, RAMDone}, 32'd0);
    check("idle_busy", {31'b0, Busy}, 32'd0);
    if (!wr)
      for (int c = 0; c < 4; c++) check("rd_hold", rd[c], exp_el(addr, 3, c));
    if (hold)
      for (int i = 0; i < 10; i++) begin
        @(negedge Clock);
        check("hold_no_rearm", {31'b0, RAMDone | Busy}, 32'd0);
      end
    RAMEnable = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    #1;
    check("rst_rowvalid", {31'b0, RowValid}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, RAMDone}, 32'd0);
    check("rst_addrerr", {31'b0, AddrError}, 32'd0);
    check("rst_rddata", RdData0, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // Bring storage to a known state.
    ClearAll = 1'b1;
    @(negedge Clock);
    ClearAll = 1'b0;
    for (int m = 0; m < 8; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) model[m][r][c] = '0;

    // Reset mid-write of row 2 at address 1.
    fill_rand();
    access(1'b1, 32'd1, -1, 1'b0, 1'b0);
    fill_rand();
    access(1'b1, 32'd1, 2, 1'b0, 1'b0);
    access(1'b0, 32'd1, -1, 1'b0, 1'b0);

    // Known pattern with a negative element.
    wdata = '{'{25, 225, 25, -35}, '{25, 25, -25, 25}, '{25, -25, 25, 25}, '{25, 325, 25, 25}};
    access(1'b1, 32'd0, -1, 1'b0, 1'b0);
    access(1'b0, 32'd0, -1, 1'b0, 1'b0);
    check("neg_elem", got_rows[0][3], 32'hFFFF_FFDD);

    // RAMEnable held high: one pulse only, then re-armed by a one-cycle drop.
    access(1'b0, 32'd0, -1, 1'b1, 1'b0);
    access(1'b0, 32'd1, -1, 1'b0, 1'b0);

    // Out-of-range read and write.
    access(1'b0, 32'd8, -1, 1'b0, 1'b0);
    fill_rand();
    access(1'b1, 32'd8, -1, 1'b0, 1'b0);

    // ClearAll together with RAMEnable in IDLE wins and blocks acceptance.
    @(negedge Clock);
    ClearAll  = 1'b1;
    RAMEnable = 1'b1;
    ReadWrite = 1'b0;
    AddressSelect = 32'd0;
    @(negedge Clock);
    check("clr_no_accept", {31'b0, RowValid | Busy}, 32'd0);
    ClearAll  = 1'b0;
    RAMEnable = 1'b0;
    for (int m = 0; m < 8; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) model[m][r][c] = '0;
    access(1'b0, 32'd0, -1, 1'b0, 1'b0);

    // ClearAll during a transfer is ignored.
    fill_rand();
    access(1'b1, 32'd5, -1, 1'b0, 1'b1);
    access(1'b0, 32'd5, -1, 1'b0, 1'b1);

    // No aliasing between addresses.
    fill_const(32'sd2);
    access(1'b1, 32'd3, -1, 1'b0, 1'b0);
    fill_const(-32'sd2);
    access(1'b1, 32'd1, -1, 1'b0, 1'b0);
    access(1'b0, 32'd3, -1, 1'b0, 1'b0);

    // Random traffic including out-of-range addresses.
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) begin
        fill_rand();
        access(1'b1, a, -1, 1'b0, 1'b0);
      end else begin
        access(1'b0, a, -1, 1'b0, 1'b0);
      end
    end

    for (int m = 0; m < 8; m++) access(1'b0, m, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_ram_responder.md
Name: matrix_ram_responder

Overview:
- Memory-side responder for the CPU's matrix RAM interface. It stores Depth signed 4x4 matrices and serves the CPU's read and write requests, one 4-word row per cycle.
- It answers the RAMEnable/ReadWrite/AddressSelect request and returns RAMDone on completion.
- It sits between the CPU and the operand/result storage used by the Add, Subtract, Transpose, ScalarMultiply, MatrixMultiply and CustomWrite operations.

Parameters:
Depth, 8, number of 4x4 matrices stored; valid addresses are 0..Depth-1.
DataWidth, 32, width of one signed matrix element.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-low reset.
RAMEnable  input  1  request from the CPU; level-sensitive, see the rearm rule.
ReadWrite  input  1  1 = write, 0 = read; sampled at acceptance.
AddressSelect  input  32  matrix index; sampled at acceptance.
ClearAll  input  1  zeroes every stored element; honoured in IDLE only.
WrData0..WrData3  input  DataWidth each, signed  elements [r][0..3] of the row RowIndex during a write.
RdData0..RdData3  output  DataWidth each, signed  elements [r][0..3] of the row RowIndex during a read.
RowIndex  output  2  row currently being transferred.
RowValid  output  1  high during each of the 4 transfer cycles.
Busy  output  1  high from the cycle after acceptance through the DONE cycle.
RAMDone  output  1  single-cycle completion pulse.
AddrError  output  1  pulses together with RAMDone when AddressSelect >= Depth.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state goes to IDLE and Armed is set to 1;
  - RdData0..3, RowIndex, RowValid, Busy, RAMDone and AddrError all go to 0;
  - any in-flight transfer is aborted, and a partially written matrix keeps the rows already written;
  - storage is NOT cleared by Reset.
- States: IDLE, XFER, DONE.
- IDLE:
  - ClearAll=1 sets all Depth*16 elements to 0 at this edge. ClearAll has priority over RAMEnable in the same cycle, and the request is not accepted.
  - Acceptance requires RAMEnable=1, Armed=1 and ClearAll=0. On acceptance: latch Addr=AddressSelect and Wr=ReadWrite, set row=0, go to XFER, and clear Armed.
  - RAMEnable=0 sampled in IDLE sets Armed=1. The CPU must drop RAMEnable before a new request is taken.
- XFER, one cycle per row r=0..3:
  - RowValid=1, RowIndex=r, Busy=1.
  - Write: at the edge ending cycle r, mem[Addr][r][c] <= WrDatac for c=0..3.
  - Read: RdData0..3 are registered and hold mem[Addr][r][0..3] throughout cycle r; they are loaded on the edge entering that cycle. Row 0 uses the address being accepted.
  - After r=3, go to DONE.
- DONE: RAMDone=1 and Busy=1 for exactly one cycle; RowValid=0; then go to IDLE.
- Latency: acceptance edge at T; rows occupy cycles T+1..T+4; RAMDone is high in T+5. Total 5 cycles per access. Back-to-back accesses need at least one cycle with RAMEnable low in IDLE.
- RdData holds its last row value after a read and outside XFER. It is zeroed only by Reset.
- Out of range (Addr >= Depth): the full 5-cycle sequence still runs. Writes are discarded, reads return 0 on every row, and AddrError=1 together with RAMDone.
- ClearAll while in XFER or DONE is ignored.
- Changes to AddressSelect or ReadWrite after acceptance have no effect.
- Arithmetic: none. Elements are stored verbatim as signed DataWidth values.

Test Plan:
1. Reset low mid-write of row 2 at address 1 -> RowValid, Busy, RAMDone and RdData all 0 immediately. Rows 0–1 of address 1 hold the new data; rows 2–3 hold the old data. The next request is accepted normally.
2. Write address 0, rows {25,225,25,-35},{25,25,-25,25},{25,-25,25,25},{25,325,25,25}, then read address 0 -> RdData reproduces each row on cycles T+1..T+4 with RowIndex 0..3. RAMDone is high only in T+5; -35 is returned as signed 0xFFFFFFDD.
3. Hold RAMEnable=1 for 10 cycles after one read -> exactly one RAMDone pulse. Drop RAMEnable for 1 cycle, raise it again -> second access accepted, done 5 cycles later.
4. Read AddressSelect=8 with Depth=8 -> 4 RowValid cycles with RdData=0, then RAMDone=1 and AddrError=1 in the same cycle. Write to address 8 -> no stored matrix changes.
5. ClearAll and RAMEnable asserted together in IDLE -> no acceptance that cycle. A read of address 0 afterwards returns all zeros. ClearAll asserted during XFER -> ignored, and the in-flight matrix is unchanged.
6. Write address 3 with all elements 2, then write address 1 with all elements -2, then read 3 -> all elements 2 (no address aliasing).
